// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered, mutually
// aligned sync, blanking and frame-marker outputs.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       vblank,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [9:0] r_draw_x;
    logic [9:0] r_draw_y;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank;
    logic       r_vblank;
    logic       r_frame_start;
    logic [7:0] r_frame_count;

    logic       w_x_wrap;
    logic       w_y_wrap;
    logic       w_frame_wrap;
    logic [9:0] w_next_x;
    logic [9:0] w_next_y;

    // Next raster position; all registered outputs decode this same value so
    // they stay aligned with the counters they are presented alongside.
    always_comb begin
        w_x_wrap     = (r_draw_x == 10'(H_TOTAL - 1));
        w_y_wrap     = (r_draw_y == 10'(V_TOTAL - 1));
        w_frame_wrap = w_x_wrap && w_y_wrap;
        w_next_x     = w_x_wrap ? 10'd0 : r_draw_x + 10'd1;
        w_next_y     = r_draw_y;
        if (w_x_wrap) begin
            w_next_y = w_y_wrap ? 10'd0 : r_draw_y + 10'd1;
        end
    end

    // Position counters and decoded timing outputs.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_draw_x      <= 10'd0;
            r_draw_y      <= 10'd0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b1;
            r_vblank      <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_draw_x      <= w_next_x;
            r_draw_y      <= w_next_y;
            r_hs          <= !((w_next_x >= 10'(HS_START)) && (w_next_x < 10'(HS_END)));
            r_vs          <= !((w_next_y >= 10'(VS_START)) && (w_next_y < 10'(VS_END)));
            r_blank       <= (w_next_x < 10'(H_VISIBLE)) && (w_next_y < 10'(V_VISIBLE));
            r_vblank      <= (w_next_y >= 10'(V_VISIBLE));
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign DrawX       = r_draw_x;
    assign DrawY       = r_draw_y;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign vblank      = r_vblank;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-raster instance exercised over 256+ frames
// with random asynchronous resets, plus a default-timing instance, both checked
// against a model derived from the cycle count since reset release.
module tb_vga_timing_gen;

    localparam int unsigned S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int unsigned S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int unsigned S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int unsigned S_FT = S_HT * (S_VV + S_VF + S_VS + S_VB);

    typedef struct {
        int unsigned x, y, hs, vs, blank, vblank, fs, fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic [9:0] s_x, s_y, d_x, d_y;
    logic       s_hs, s_vs, s_blank, s_vblank, s_fs;
    logic       d_hs, d_vs, d_blank, d_vblank, d_fs;
    logic [7:0] s_fc, d_fc;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned n       = 0;
    int unsigned pulses  = 0;
    int unsigned max_fc  = 0;
    logic        prev_fs = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) u_small (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y),
        .hs(s_hs), .vs(s_vs), .blank(s_blank), .vblank(s_vblank),
        .frame_start(s_fs), .frame_count(s_fc)
    );

    vga_timing_gen u_dflt (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y),
        .hs(d_hs), .vs(d_vs), .blank(d_blank), .vblank(d_vblank),
        .frame_start(d_fs), .frame_count(d_fc)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (n=%0d, t=%0t)", tag, obs, exp, n, $time);
        end
    endtask

    // Expected outputs after c rising edges since reset release, from the timing rules.
    function automatic exp_t model(input int unsigned c,
                                   input int unsigned hv, input int unsigned hf,
                                   input int unsigned hsw, input int unsigned hb,
                                   input int unsigned vv, input int unsigned vf,
                                   input int unsigned vsw, input int unsigned vb);
        exp_t e;
        int unsigned ht = hv + hf + hsw + hb;
        int unsigned vt = vv + vf + vsw + vb;
        int unsigned ft = ht * vt;
        e.x      = c % ht;
        e.y      = (c / ht) % vt;
        e.hs     = (e.x >= hv + hf && e.x < hv + hf + hsw) ? 0 : 1;
        e.vs     = (e.y >= vv + vf && e.y < vv + vf + vsw) ? 0 : 1;
        e.blank  = (e.x < hv && e.y < vv) ? 1 : 0;
        e.vblank = (e.y >= vv) ? 1 : 0;
        e.fs     = (c > 0 && c % ft == 0) ? 1 : 0;
        e.fc     = (c / ft) % 256;
        return e;
    endfunction

    task automatic check_outputs();
        exp_t es, ed;
        es = model(n, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
        ed = model(n, 640, 16, 96, 48, 480, 10, 2, 33);
        check("s_x",      32'(s_x),      es.x);
        check("s_y",      32'(s_y),      es.y);
        check("s_hs",     32'(s_hs),     es.hs);
        check("s_vs",     32'(s_vs),     es.vs);
        check("s_blank",  32'(s_blank),  es.blank);
        check("s_vblank", 32'(s_vblank), es.vblank);
        check("s_fs",     32'(s_fs),     es.fs);
        check("s_fc",     32'(s_fc),     es.fc);
        check("d_x",      32'(d_x),      ed.x);
        check("d_y",      32'(d_y),      ed.y);
        check("d_hs",     32'(d_hs),     ed.hs);
        check("d_vs",     32'(d_vs),     ed.vs);
        check("d_blank",  32'(d_blank),  ed.blank);
        check("d_vblank", 32'(d_vblank), ed.vblank);
        check("d_fs",     32'(d_fs),     ed.fs);
        check("d_fc",     32'(d_fc),     ed.fc);
        check("s_fs_consec", 32'(prev_fs && s_fs), 0);
        check("s_x_range", (32'(s_x) < S_HT) ? 1 : 0, 1);
        check("d_x_range", (32'(d_x) < 800) ? 1 : 0, 1);
        check("d_y_range", (32'(d_y) < 525) ? 1 : 0, 1);
        if (s_fs) pulses++;
        if (32'(s_fc) > max_fc) max_fc = 32'(s_fc);
        prev_fs = s_fs;
    endtask

    // One clock: count the edge if out of reset, then sample on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset_n) n++;
        @(negedge clk);
        check_outputs();
    endtask

    // Reset asserted between edges must take effect without any clock edge.
    task automatic async_reset(input int unsigned hold);
        #2;
        reset_n = 1'b0;
        n = 0;
        #1;
        check_outputs();
        for (int i = 0; i < int'(hold); i++) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int unsigned target;
        repeat (2) tick();
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // 256 full frames of the small raster: frame_count must wrap back to 0.
        pulses = 0;
        max_fc = 0;
        for (int i = 0; i < int'(256 * S_FT); i++) tick();
        check("pulses_256", pulses, 256);
        check("max_fc", max_fc, 255);
        check("fc_wrapped", 32'(s_fc), 0);
        check("fs_at_wrap", 32'(s_fs), 1);

        // Random mid-frame resets.
        for (int k = 0; k < 16; k++) begin
            int unsigned run = $urandom_range(1, 2 * S_FT);
            for (int i = 0; i < int'(run); i++) tick();
            async_reset($urandom_range(1, 3));
        end

        // Reset while both syncs are low, then resume.
        target = (S_VV + S_VF + 1) * S_HT + (S_HV + S_HF + 1);
        for (int i = 0; i < int'(target); i++) tick();
        check("pre_hs_low", 32'(s_hs), 0);
        check("pre_vs_low", 32'(s_vs), 0);
        async_reset(2);
        tick();
        check("resume_x", 32'(s_x), 1);
        check("resume_y", 32'(s_y), 0);
        for (int i = 0; i < int'(2 * S_FT); i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
